stream_demux_n: RTL and testbench
=================================

STREAM_DEMUX_N -- requirements
Module: stream_demux_n

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits per beat.
REQ-002 Parameter NUM_CH, default 5: number of output channels; legal range 1 to 2**SEL_W-1.
REQ-003 Parameter SEL_W, default 3: width of the channel select input.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sel  in  SEL_W  channel select; value k in 1..NUM_CH selects channel k-1; 0 or >NUM_CH is invalid.
REQ-007 s_tdata  in  DATA_W  input payload.
REQ-008 s_tvalid  in  1  input beat valid.
REQ-009 s_tlast  in  1  input beat is last of packet.
REQ-010 s_tready  out  1  input beat accepted when s_tvalid && s_tready.
REQ-011 m_tdata  out  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
REQ-012 m_tvalid  out  NUM_CH  per-channel valid.
REQ-013 m_tlast  out  NUM_CH  per-channel last.
REQ-014 m_tready  in  NUM_CH  per-channel ready.
REQ-015 busy  out  1  high while a packet is open or a beat is held in the output register.
REQ-016 drop_cnt  out  8  count of whole packets discarded due to invalid sel, saturating.

Function
REQ-017 The block SHALL hold one output register: data, last, channel index och, and valid flag ov.
REQ-018 The FSM SHALL have exactly three states:
- IDLE: no packet open.
- PASS: packet open to a latched channel lch.
- DROP: packet being discarded.
REQ-019 In IDLE, sel SHALL be decoded combinationally only for the first beat of a packet.
REQ-020 In PASS and DROP, sel SHALL be ignored until the tlast beat has been accepted.
REQ-021 The output register SHALL be free when ov==0, or when ov==1 and m_tready[och]==1 in the same cycle.
REQ-022 In IDLE with valid sel, and in PASS, s_tready SHALL equal the output-register-free condition, independent of s_tvalid.
REQ-023 In DROP, and in IDLE with invalid sel, s_tready SHALL be 1.
REQ-024 An accepted beat in IDLE with valid sel k SHALL load the output register with och=k-1.
- If s_tlast==0, the FSM SHALL go to PASS with lch=k-1.
- If s_tlast==1, the FSM SHALL stay in IDLE.
REQ-025 An accepted beat in PASS SHALL load the output register with och=lch, and the FSM SHALL return to IDLE on s_tlast==1.
REQ-026 An accepted beat in IDLE with invalid sel SHALL be discarded.
- If s_tlast==1, the FSM SHALL stay in IDLE and drop_cnt SHALL increment.
- If s_tlast==0, the FSM SHALL go to DROP.
REQ-027 In DROP, beats SHALL be discarded, and the tlast beat SHALL increment drop_cnt and return the FSM to IDLE.
REQ-028 drop_cnt SHALL saturate at 255 and never wrap.
REQ-029 Channel outputs SHALL be driven as follows:
- m_tvalid[i] = ov && (och==i).
- m_tlast[i] = ov && (och==i) && stored last.
- m_tdata lane i = stored data when och==i, otherwise all zeros.
REQ-030 Latency SHALL be exactly one cycle from input handshake to m_tvalid assertion.
REQ-031 Throughput SHALL be one beat per cycle while the destination holds m_tready high.
REQ-032 On a simultaneous drain of the held beat and load of a new beat, the register SHALL take the new beat and ov SHALL stay 1.
REQ-033 The new beat MAY target a different channel than the drained one; no idle cycle SHALL be inserted between packets.
REQ-034 When ov==0 and no beat is accepted, ov SHALL stay 0.
REQ-035 m_tready of channels other than och SHALL have no effect.
REQ-036 A held beat SHALL keep its data, last and och stable until drained.
REQ-037 busy SHALL equal (state!=IDLE) || ov.

Reset
REQ-038 While rst is high, the block SHALL asynchronously force: state=IDLE, ov=0, och=0, lch=0, stored data=0, stored last=0, drop_cnt=0.
REQ-039 While rst is high, all outputs SHALL read: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, drop_cnt=0.
REQ-040 Reset asserted mid-packet SHALL discard the partial packet and the held beat, with no further output for that packet.
REQ-041 After reset deassertion, the next beat SHALL be treated as a packet's first beat.

Verification
REQ-042 Single-beat route: sel=3, s_tdata=0xA5, s_tlast=1, m_tready all 1 -> next cycle m_tvalid=00100, lane 2=0xA5, m_tlast[2]=1, all other lanes 0.
REQ-043 Sel locked mid-packet: 4-beat packet 0x01..0x04 with sel=1, sel changed to 5 after beat 1 -> all 4 beats on channel 0 only, tlast on beat 0x04, busy low afterwards.
REQ-044 Backpressure: m_tready[1]=0 for 3 cycles during a sel=2 stream -> s_tready=0 in those cycles, the held beat stays stable, no loss or duplication, stream resumes at 1 beat/cycle.
REQ-045 Invalid sel: sel=0 with a 3-beat packet, then sel=7 with a 1-beat packet (NUM_CH=5) -> s_tready=1 throughout, no m_tvalid, drop_cnt=2.
REQ-046 Back-to-back channel switch and saturation:
- Packet to channel 0 immediately followed by a packet to channel 4 -> no idle cycle between them.
- 260 invalid packets -> drop_cnt=255.
REQ-047 Async reset mid-packet: rst pulsed off-edge during beat 2 of a sel=4 packet -> outputs clear immediately; next packet with sel=1 routes to channel 0.

Source files
------------

// File: rtl/stream_demux_n.sv
// stream_demux_n: routes each packet to the channel picked by sel on its first beat.
// Packets with an out-of-range sel are swallowed and counted.
module stream_demux_n #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 5,
   parameter int SEL_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SEL_W-1:0]         sel,
   input  logic [DATA_W-1:0]        s_tdata,
   input  logic                     s_tvalid,
   input  logic                     s_tlast,
   output logic                     s_tready,
   output logic [NUM_CH*DATA_W-1:0] m_tdata,
   output logic [NUM_CH-1:0]        m_tvalid,
   output logic [NUM_CH-1:0]        m_tlast,
   input  logic [NUM_CH-1:0]        m_tready,
   output logic                     busy,
   output logic [7:0]               drop_cnt
);
   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CH);
   state_t state, nstate;
   logic [SEL_W-1:0] och, lch, ld_ch;
   logic [DATA_W-1:0] dreg;
   logic lreg, ov, sel_ok, free, acc, load, drop_end;
   assign sel_ok = sel != '0 && sel <= MAX_SEL;
   assign free = !ov || m_tready[och];
   assign acc = s_tvalid && s_tready;
   assign load = acc && (state == PASS || (state == IDLE && sel_ok));
   assign drop_end = acc && s_tlast && (state == DROP || (state == IDLE && !sel_ok));
   assign ld_ch = state == PASS ? lch : sel - SEL_W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nstate;
   always_comb
      nstate = !acc ? state : s_tlast ? IDLE : state == IDLE ? (sel_ok ? PASS : DROP) : state;
   // Discarded beats never touch the output register, so dropping is always ready.
   always_comb begin
      s_tready = state == DROP || (state == IDLE && !sel_ok) || free;
      busy = state != IDLE || ov;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ov <= 1'b0;
         och <= '0;
         lch <= '0;
         dreg <= '0;
         lreg <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (load) begin
            och <= ld_ch;
            dreg <= s_tdata;
            lreg <= s_tlast;
         end
         ov <= load || (ov && !m_tready[och]);
         if (acc && state == IDLE && sel_ok && !s_tlast) lch <= ld_ch;
         if (drop_end && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = ov && och == SEL_W'(i);
      assign m_tvalid[i] = hit;
      assign m_tlast[i] = hit && lreg;
      assign m_tdata[i*DATA_W +: DATA_W] = hit ? dreg : '0;
   end
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: random and directed packets checked by a queue scoreboard
// against a packet-level model of routing, dropping and the drop counter.
module tb_stream_demux_n;
   localparam int DATA_W = 8, NUM_CH = 5, SEL_W = 3;
   logic clk = 0, rst = 1;
   logic [SEL_W-1:0] sel = '0;
   logic [DATA_W-1:0] s_tdata = '0;
   logic s_tvalid = 0, s_tlast = 0, s_tready, busy;
   logic [NUM_CH*DATA_W-1:0] m_tdata;
   logic [NUM_CH-1:0] m_tvalid, m_tlast, m_tready = '1, rdy_fix = '1;
   logic [7:0] drop_cnt;
   int rdy_mode = 0;
   int pass_cnt = 0, tot_cnt = 0;
   typedef struct {int ch; logic [7:0] data; logic last;} beat_t;
   beat_t exp_q[$];
   int dest = -1;  // -1: no packet open, -2: dropping, else open channel
   int drops = 0;
   logic acc_l = 0, last_l = 0;
   logic [SEL_W-1:0] sel_l = '0;
   logic [DATA_W-1:0] dat_l = '0;

   stream_demux_n #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .sel(sel), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   function automatic bit sel_valid(int s);
      return s >= 1 && s <= NUM_CH;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      acc_l = !rst && s_tvalid && s_tready;
      sel_l = sel;
      dat_l = s_tdata;
      last_l = s_tlast;
   end

   // Packet-level reference: first beat decides the fate of the whole packet.
   always @(posedge clk or posedge rst)
      if (rst) begin
         exp_q.delete();
         dest = -1;
         drops = 0;
      end else if (acc_l) begin
         if (dest == -1) begin
            if (sel_valid(int'(sel_l))) begin
               exp_q.push_back('{int'(sel_l) - 1, dat_l, last_l});
               if (!last_l) dest = int'(sel_l) - 1;
            end else if (last_l) drops = drops < 255 ? drops + 1 : 255;
            else dest = -2;
         end else if (dest == -2) begin
            if (last_l) begin
               drops = drops < 255 ? drops + 1 : 255;
               dest = -1;
            end
         end else begin
            exp_q.push_back('{dest, dat_l, last_l});
            if (last_l) dest = -1;
         end
      end

   always @(negedge clk)
      if (!rst) begin
         logic free;
         logic [NUM_CH-1:0] ev, el;
         logic [NUM_CH*DATA_W-1:0] ed;
         free = 1'b1;
         ev = '0;
         el = '0;
         ed = '0;
         if (exp_q.size() > 0) begin
            ev[exp_q[0].ch] = 1'b1;
            el[exp_q[0].ch] = exp_q[0].last;
            ed[exp_q[0].ch*DATA_W +: DATA_W] = exp_q[0].data;
            free = m_tready[exp_q[0].ch];
         end
         chk("m_tvalid", m_tvalid, ev);
         chk("m_tdata", m_tdata, ed);
         chk("m_tlast", m_tlast, el);
         chk("s_tready", s_tready, (dest == -2 || (dest == -1 && !sel_valid(int'(sel)))) ? 1'b1 : free);
         chk("busy", busy, dest != -1 || exp_q.size() > 0);
         chk("drop_cnt", drop_cnt, drops);
         if (exp_q.size() > 0 && free) void'(exp_q.pop_front());
      end

   initial forever begin
      @(posedge clk);
      #1;
      m_tready = rdy_mode == 0 ? '1 : rdy_mode == 1 ? NUM_CH'($urandom) : rdy_fix;
   end

   task automatic send_beat(input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d, input logic l);
      int n;
      bit ok;
      n = 0;
      ok = 0;
      sel = s;
      s_tdata = d;
      s_tlast = l;
      s_tvalid = 1;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = s_tready;
         n++;
      end
      chk("handshake", ok, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int s, input int len, input logic [7:0] base, input bit gaps, input int later);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_tvalid = 0;
            s_tdata = DATA_W'($urandom);
            repeat ($urandom_range(1, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         send_beat(i == 0 ? SEL_W'(s) : later < 0 ? SEL_W'($urandom) : SEL_W'(later),
                   base + 8'(i), i == len - 1);
      end
   endtask

   task automatic idle(input int n);
      s_tvalid = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset();
      chk("rst_m_tvalid", m_tvalid, '0);
      chk("rst_m_tlast", m_tlast, '0);
      chk("rst_m_tdata", m_tdata, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop_cnt", drop_cnt, 8'd0);
   endtask

   initial begin
      #12;
      chk_reset();
      @(negedge clk);
      #2 rst = 0;
      @(posedge clk);
      #1;
      send_pkt(3, 1, 8'hA5, 0, -1);
      idle(3);
      send_pkt(1, 4, 8'h01, 0, 5);
      idle(3);
      chk("busy_after_lock", busy, 1'b0);
      rdy_mode = 2;
      rdy_fix = '1;
      fork
         send_pkt(2, 10, 8'h40, 0, -1);
         begin
            repeat (3) @(posedge clk);
            rdy_fix = 5'b11101;
            repeat (3) @(posedge clk);
            rdy_fix = '1;
         end
      join
      idle(3);
      rdy_mode = 0;
      send_pkt(0, 3, 8'h10, 0, -1);
      send_pkt(7, 1, 8'h20, 0, -1);
      idle(2);
      chk("drop_cnt_two", drop_cnt, 8'd2);
      send_pkt(1, 3, 8'h60, 0, -1);
      send_pkt(5, 3, 8'h70, 0, -1);
      idle(3);
      rdy_mode = 1;
      for (int p = 0; p < 150; p++)
         send_pkt($urandom_range(0, 7), $urandom_range(1, 4), 8'($urandom), 1, -1);
      rdy_mode = 0;
      idle(5);
      chk("drained", exp_q.size(), 0);
      for (int p = 0; p < 260; p++) send_pkt(p % 2 == 0 ? 0 : 6, 1, 8'(p), 0, -1);
      idle(2);
      chk("drop_sat", drop_cnt, 8'd255);
      send_pkt(4, 1, 8'hC1, 0, -1);
      sel = 3'd4;
      s_tdata = 8'hC2;
      s_tlast = 0;
      s_tvalid = 1;
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk_reset();
      s_tvalid = 0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 0;
      @(posedge clk);
      #1;
      send_pkt(1, 2, 8'hD0, 0, -1);
      idle(3);
      chk("post_reset_drained", exp_q.size(), 0);
      chk("post_reset_busy", busy, 1'b0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
